// File: rtl/board_tile_streamer_if.sv
// Tile transfer channel between the board reader and the tile renderer.
// The streamer drives the master side; the renderer answers with tile_ready.
interface board_tile_streamer_if #(
   parameter int EXP_W = 4
);
   logic             tile_valid;
   logic             tile_ready;
   logic [3:0]       tile_idx;
   logic [EXP_W-1:0] tile_exp;

   modport master (output tile_valid, output tile_idx, output tile_exp, input tile_ready);
   modport slave  (input tile_valid, input tile_idx, input tile_exp, output tile_ready);
endinterface

// File: rtl/board_tile_streamer.sv
// Snapshots the selected 4x4 board and streams its tiles over a valid/ready
// channel, accumulating occupied-tile count and maximum exponent per frame.
module board_tile_streamer #(
   parameter int EXP_W      = 4,
   parameter bit SKIP_EMPTY = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [16*EXP_W-1:0]   board,
   input  logic [3:0]            mode,
   input  logic                  start,
   board_tile_streamer_if.master tile,
   output logic                  busy,
   output logic                  done,
   output logic [4:0]            occ_cnt,
   output logic [EXP_W-1:0]      max_exp
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t              state;
   logic [16*EXP_W-1:0] snapshot;
   logic [16*EXP_W-1:0] capture;
   logic                first_found;
   logic [3:0]          first_idx;
   logic                next_found;
   logic [3:0]          next_idx;
   logic                xfer;

   // Lowest index >= lo holding a nonzero exponent; result is {found, idx}.
   function automatic logic [4:0] find_from(input logic [16*EXP_W-1:0] b, input logic [4:0] lo);
      logic [4:0] r;
      r = '0;
      for (int unsigned i = 16; i > 0; i--) begin
         if ((i - 1) >= 32'(lo) && b[EXP_W*(i-1) +: EXP_W] != '0)
            r = {1'b1, 4'(i - 1)};
      end
      return r;
   endfunction

   always_comb begin
      capture     = (mode == 4'b0011 || mode == 4'b0100) ? board : '0;
      xfer        = tile.tile_valid && tile.tile_ready;
      first_found = 1'b1;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      if (SKIP_EMPTY) begin
         {first_found, first_idx} = find_from(capture, 5'd0);
         {next_found, next_idx}   = find_from(snapshot, {1'b0, tile.tile_idx} + 5'd1);
      end else begin
         next_found = (tile.tile_idx != 4'd15);
         next_idx   = tile.tile_idx + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         snapshot      <= '0;
         tile.tile_valid <= 1'b0;
         tile.tile_idx <= '0;
         tile.tile_exp <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         occ_cnt       <= '0;
         max_exp       <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  snapshot <= capture;
                  occ_cnt  <= '0;
                  max_exp  <= '0;
                  busy     <= 1'b1;
                  if (first_found) begin
                     state           <= SEND;
                     tile.tile_valid <= 1'b1;
                     tile.tile_idx   <= first_idx;
                     tile.tile_exp   <= capture[EXP_W*first_idx +: EXP_W];
                  end else begin
                     // Nothing to emit: go straight to the frame-end pulse.
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (xfer) begin
                  occ_cnt <= occ_cnt + 5'(tile.tile_exp != '0);
                  if (tile.tile_exp > max_exp)
                     max_exp <= tile.tile_exp;
                  if (next_found) begin
                     tile.tile_idx <= next_idx;
                     tile.tile_exp <= snapshot[EXP_W*next_idx +: EXP_W];
                  end else begin
                     tile.tile_valid <= 1'b0;
                     done            <= 1'b1;
                     state           <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_tile_streamer.sv
// Directed bench for board_tile_streamer: one instance without and one with
// empty-tile skipping, driven one at a time through a shared stimulus set.
module tb_board_tile_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        ready;
   logic        which;
   logic [63:0] board;
   logic [3:0]  mode;

   always #5 clk = ~clk;

   board_tile_streamer_if #(.EXP_W(4)) t0 ();
   board_tile_streamer_if #(.EXP_W(4)) t1 ();

   logic       start0, start1;
   logic       busy0, busy1, done0, done1;
   logic [4:0] occ0, occ1;
   logic [3:0] max0, max1;

   assign t0.tile_ready = ready;
   assign t1.tile_ready = ready;
   assign start0 = start & ~which;
   assign start1 = start & which;

   board_tile_streamer #(.EXP_W(4), .SKIP_EMPTY(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .board(board), .mode(mode), .start(start0),
      .tile(t0.master), .busy(busy0), .done(done0), .occ_cnt(occ0), .max_exp(max0));

   board_tile_streamer #(.EXP_W(4), .SKIP_EMPTY(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .board(board), .mode(mode), .start(start1),
      .tile(t1.master), .busy(busy1), .done(done1), .occ_cnt(occ1), .max_exp(max1));

   logic       v, dn, bs;
   logic [3:0] idx, ex, mx;
   logic [4:0] oc;
   assign v  = which ? t1.tile_valid : t0.tile_valid;
   assign idx = which ? t1.tile_idx  : t0.tile_idx;
   assign ex = which ? t1.tile_exp   : t0.tile_exp;
   assign dn = which ? done1 : done0;
   assign bs = which ? busy1 : busy0;
   assign oc = which ? occ1  : occ0;
   assign mx = which ? max1  : max0;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_idx [16];
   logic [3:0] exp_exp [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(v), 0);
      chk({tag, "_idx"}, 32'(idx), 0);
      chk({tag, "_exp"}, 32'(ex), 0);
      chk({tag, "_busy"}, 32'(bs), 0);
      chk({tag, "_done"}, 32'(dn), 0);
      chk({tag, "_occ"}, 32'(oc), 0);
      chk({tag, "_max"}, 32'(mx), 0);
   endtask

   // Runs one frame; pat 0 = ready always high, pat 1 = ready 1,0,0 repeating.
   task automatic stream(input int n, input int pat, input bit disturb,
                         input int e_occ, input int e_max);
      int         got = 0;
      int         cyc = 0;
      int         done_seen = 0;
      logic       pv = 1'b0, pr = 1'b0;
      logic [3:0] pidx = '0, pexp = '0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (got < n && cyc < 400) begin
         if (dn) done_seen++;
         ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
         if (pv && !pr) begin
            chk("stall_idx", 32'(idx), 32'(pidx));
            chk("stall_exp", 32'(ex), 32'(pexp));
         end
         if (which && v) chk("skip_nonzero", 32'(ex != 0), 1);
         if (v && ready) begin
            chk("xfer_idx", 32'(idx), 32'(exp_idx[got]));
            chk("xfer_exp", 32'(ex), 32'(exp_exp[got]));
            got++;
         end
         if (disturb && cyc == 2) begin
            board = ~board;
            mode  = 4'b0001;
            start = 1'b1;
         end
         if (disturb && cyc == 3) start = 1'b0;
         pv = v; pr = ready; pidx = idx; pexp = ex;
         @(posedge clk); #1;
         cyc++;
      end
      chk("xfer_count", 32'(got), 32'(n));
      chk("done_early", 32'(done_seen), 0);
      chk("done_pulse", 32'(dn), 1);
      chk("done_valid", 32'(v), 0);
      chk("done_busy", 32'(bs), 1);
      chk("occ_cnt", 32'(oc), 32'(e_occ));
      chk("max_exp", 32'(mx), 32'(e_max));
      @(posedge clk); #1;
      chk("post_done", 32'(dn), 0);
      chk("post_busy", 32'(bs), 0);
      chk("post_occ_hold", 32'(oc), 32'(e_occ));
      if (disturb) begin
         repeat (3) begin
            @(posedge clk); #1;
            chk("no_requeue_valid", 32'(v), 0);
            chk("no_requeue_busy", 32'(bs), 0);
            chk("no_requeue_done", 32'(dn), 0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; which = 1'b0;
      board = 64'h0123456789ABCDEF; mode = 4'b0011;
      #2;
      check_all_zero("reset");
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a frame
      start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("pre_reset_idx", 32'(idx), 32'(k));
         chk("pre_reset_exp", 32'(ex), 32'(15 - k));
         @(posedge clk); #1;
      end
      chk("pre_reset_occ", 32'(oc), 5);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) begin
         @(posedge clk); #1;
         chk("midreset_no_done", 32'(dn), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_valid", 32'(v), 1);
      chk("restart_idx", 32'(idx), 0);
      chk("restart_exp", 32'(ex), 4'hF);
      ready = 1'b0;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(posedge clk); #1;

      // Full stream with backpressure
      for (int k = 0; k < 16; k++) begin
         exp_idx[k] = 4'(k);
         exp_exp[k] = 4'(15 - k);
      end
      stream(16, 1, 1'b0, 15, 15);

      // Invalid mode streams a blank board
      board = 64'hFFFF_FFFF_FFFF_FFFF; mode = 4'b0001;
      for (int k = 0; k < 16; k++) exp_exp[k] = 4'h0;
      stream(16, 0, 1'b0, 0, 0);

      // Skip empty tiles
      which = 1'b1;
      board = 64'h0000_0000_0300_0010; mode = 4'b0100;
      exp_idx[0] = 4'd1; exp_exp[0] = 4'd1;
      exp_idx[1] = 4'd6; exp_exp[1] = 4'd3;
      stream(2, 1, 1'b0, 2, 3);

      // Empty board with skipping: straight to done
      board = 64'h0; mode = 4'b0011;
      stream(0, 0, 1'b0, 0, 0);

      // Snapshot isolation and ignored start during SEND
      which = 1'b0;
      board = 64'h0123456789ABCDEF; mode = 4'b0100;
      for (int k = 0; k < 16; k++) begin
         exp_idx[k] = 4'(k);
         exp_exp[k] = 4'(15 - k);
      end
      stream(16, 0, 1'b1, 15, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_tile_streamer.md
Name: board_tile_streamer

Overview:
- Reader side of the 64-bit board bus: snapshots the selected 4x4 board and streams its 16 tiles, one 4-bit exponent per transfer, over a valid/ready interface to the tile renderer.
- Board selection codes are the ones the board mux uses: 4'b0011 (game board 1), 4'b0100 (game board 2); any other mode streams a blank board.
- Also reports per-frame statistics: occupied-tile count and maximum exponent.

Parameters:
- EXP_W, 4, bits per tile exponent (board width = 16*EXP_W)
- SKIP_EMPTY, 0, 1 = tiles with exponent 0 are not emitted

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- board  input  16*EXP_W  selected board; tile i = board[EXP_W*i +: EXP_W]
- mode  input  4  board-select code, sampled only at start
- start  input  1  request one frame scan, honoured only in IDLE
- tile_ready  input  1  renderer accepts current tile
- tile_valid  output  1  tile_idx/tile_exp hold a valid tile
- tile_idx  output  4  tile index 0..15; row = idx[3:2], col = idx[1:0]
- tile_exp  output  EXP_W  exponent of tile (0 = empty)
- busy  output  1  high from start acceptance until done pulse inclusive
- done  output  1  one-cycle pulse at frame end
- occ_cnt  output  5  nonzero tiles in last frame, 0..16
- max_exp  output  EXP_W  largest exponent in last frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; tile_valid=0, tile_idx=0, tile_exp=0, busy=0, done=0, occ_cnt=0, max_exp=0, snapshot=0. Reset mid-frame aborts the scan; no done pulse.
- FSM states IDLE, SEND, DONE.
- IDLE: on start=1 at an edge, capture snapshot = (mode==4'b0011 || mode==4'b0100) ? board : 0. Clear stat accumulators. busy=1. Go to SEND.
- Snapshot isolation: board/mode changes after capture do not affect the frame.
- SEND: tile_valid=1 from the first cycle after start (1-cycle latency). tile_idx/tile_exp stay stable while tile_valid && !tile_ready.
- Transfer occurs when tile_valid && tile_ready. On transfer, occ_cnt += (exp!=0) and max_exp = max(max_exp, exp). The pointer then advances to the next emitted index.
- SKIP_EMPTY=0: indices 0..15 in order, 16 transfers per frame.
- SKIP_EMPTY=1: pointer goes to the next higher index with a nonzero exponent, searched combinationally from the snapshot. If none remains, the frame ends. tile_valid is never asserted for an empty tile.
- Frame end: transfer of the last tile goes to DONE. With SKIP_EMPTY=1 and an all-zero snapshot, SEND is skipped: IDLE -> DONE directly, with no tile_valid.
- DONE: done=1 and tile_valid=0 for exactly one cycle. occ_cnt/max_exp are final and held until the next accepted start. Next state is IDLE; busy drops the cycle after done.
- start while busy is ignored (not queued). start in the DONE cycle is ignored.
- tile_ready while tile_valid=0 has no effect.
- Stats accumulate only from transferred tiles. Counters are sized so 16 does not wrap (5 bits).

Test Plan:
- Reset mid-stream: start with board=64'h0123456789ABCDEF, mode=4'b0011, tile_ready=1; assert rst_n=0 after 5 transfers -> all outputs 0 immediately, no done; a new start restreams from idx 0.
- Full stream with backpressure: same board, mode=4'b0011, SKIP_EMPTY=0, tile_ready toggling 1,0,0,1... -> 16 transfers, idx 0..15 with exp F,E,D,...,0. Data is stable during stalls. done one cycle after the last transfer; occ_cnt=15, max_exp=F.
- Invalid mode: board=64'hFFFF_FFFF_FFFF_FFFF, mode=4'b0001, SKIP_EMPTY=0 -> 16 tiles all exp 0; occ_cnt=0, max_exp=0.
- Skip empty: SKIP_EMPTY=1, board=64'h0000_0000_0300_0010, mode=4'b0100 -> exactly two transfers, (idx 1, exp 1) then (idx 6, exp 3); occ_cnt=2, max_exp=3.
- Empty board with SKIP_EMPTY=1 -> no tile_valid, done pulses 1 cycle after start, occ_cnt=0.
- Snapshot/start isolation: change board and pulse start during SEND -> streamed values match the captured board; the extra start is ignored; exactly one done.
